// File: rtl/vec_seq.sv
// Vector sequencer: streams operand pairs from two memories through an external
// combinational modular ALU and writes results back, one element per cycle.
module vec_seq #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [63:0]       cfg_q,
    input  logic [63:0]       cfg_mu,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [63:0]       rd_data_a,
    input  logic [63:0]       rd_data_b,
    output logic [2:0]        alu_opcode,
    output logic [63:0]       alu_a,
    output logic [63:0]       alu_b,
    output logic [63:0]       alu_q,
    output logic [63:0]       alu_mu,
    input  logic [63:0]       alu_res,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(0);

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t              state_r;
    state_t              next_state_s;

    logic [2:0]          op_r;
    logic [ADDR_W-1:0]   dst_r;
    logic [ADDR_W-1:0]   len_r;
    logic [63:0]         q_r;
    logic [63:0]         mu_r;

    logic [ADDR_W-1:0]   rd_idx_r;
    logic                rd_en_r;
    logic [ADDR_W-1:0]   rd_addr_a_r;
    logic [ADDR_W-1:0]   rd_addr_b_r;

    logic                rd_v_d1_r;
    logic [ADDR_W-1:0]   idx_d1_r;

    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [63:0]         wr_data_r;

    logic                done_r;
    logic                err_r;
    logic                busy_r;
    logic                cmd_ready_r;

    logic                accept_s;
    logic                last_s;
    logic                rd_en_s;
    logic [ADDR_W-1:0]   rd_idx_s;
    logic [ADDR_W-1:0]   rd_addr_a_s;
    logic [ADDR_W-1:0]   rd_addr_b_s;
    logic                done_s;
    logic                err_s;
    logic                busy_s;
    logic                cmd_ready_s;
    logic [2:0]          fin_op_s;

    assign accept_s = cmd_valid & cmd_ready_r;
    assign last_s   = (rd_idx_r == (len_r - ONE_A));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; DRAIN exits once the final write is on the port
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (op_legal(cmd_opcode) && (cmd_len != ZERO_A)) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = FIN;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = RUN;
                end
            end
            DRAIN: begin
                if (wr_en_r && !rd_v_d1_r) begin
                    next_state_s = FIN;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            FIN:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output logic: next values of the registered control/address outputs
    always_comb begin
        rd_idx_s    = rd_idx_r;
        rd_addr_a_s = rd_addr_a_r;
        rd_addr_b_s = rd_addr_b_r;
        fin_op_s    = op_r;
        case (state_r)
            IDLE: begin
                fin_op_s = cmd_opcode;
                if (accept_s) begin
                    rd_idx_s    = ZERO_A;
                    rd_addr_a_s = cmd_src_a;
                    rd_addr_b_s = cmd_src_b;
                end else begin
                    rd_idx_s    = rd_idx_r;
                end
            end
            RUN: begin
                if (!last_s) begin
                    rd_idx_s    = rd_idx_r + ONE_A;
                    rd_addr_a_s = rd_addr_a_r + ONE_A;
                    rd_addr_b_s = rd_addr_b_r + ONE_A;
                end else begin
                    rd_idx_s    = rd_idx_r;
                end
            end
            default: begin
                rd_idx_s = rd_idx_r;
            end
        endcase
        rd_en_s     = (next_state_s == RUN);
        done_s      = (next_state_s == FIN);
        err_s       = done_s & ~op_legal(fin_op_s);
        busy_s      = (next_state_s != IDLE);
        cmd_ready_s = (next_state_s == IDLE);
    end

    // Command and configuration capture at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= 3'b000;
            dst_r <= ZERO_A;
            len_r <= ZERO_A;
            q_r   <= 64'd0;
            mu_r  <= 64'd0;
        end else if (accept_s) begin
            op_r  <= cmd_opcode;
            dst_r <= cmd_dst;
            len_r <= cmd_len;
            q_r   <= cfg_q;
            mu_r  <= cfg_mu;
        end else begin
            op_r  <= op_r;
        end
    end

    // Read issue and status output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx_r    <= ZERO_A;
            rd_en_r     <= 1'b0;
            rd_addr_a_r <= ZERO_A;
            rd_addr_b_r <= ZERO_A;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            rd_idx_r    <= rd_idx_s;
            rd_en_r     <= rd_en_s;
            rd_addr_a_r <= rd_addr_a_s;
            rd_addr_b_r <= rd_addr_b_s;
            done_r      <= done_s;
            err_r       <= err_s;
            busy_r      <= busy_s;
            cmd_ready_r <= cmd_ready_s;
        end
    end

    // Read-data alignment stage: element index travels with the memory latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v_d1_r <= 1'b0;
            idx_d1_r  <= ZERO_A;
        end else begin
            rd_v_d1_r <= rd_en_r;
            idx_d1_r  <= rd_idx_r;
        end
    end

    // Result write stage: ALU output registered straight onto the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= ZERO_A;
            wr_data_r <= 64'd0;
        end else if (rd_v_d1_r) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= dst_r + idx_d1_r;
            wr_data_r <= alu_res;
        end else begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
        end
    end

    // Operands are gated to zero outside their valid cycle so reset clears them too
    assign alu_a      = rd_v_d1_r ? rd_data_a : 64'd0;
    assign alu_b      = rd_v_d1_r ? rd_data_b : 64'd0;
    assign alu_opcode = op_r;
    assign alu_q      = q_r;
    assign alu_mu     = mu_r;

    assign rd_en      = rd_en_r;
    assign rd_addr_a  = rd_addr_a_r;
    assign rd_addr_b  = rd_addr_b_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign done       = done_r;
    assign err        = err_r;
    assign busy       = busy_r;
    assign cmd_ready  = cmd_ready_r;

endmodule

// File: tb/tb_vec_seq.sv
// Directed, table-driven bench for vec_seq with memory and modular ALU models.
module tb_vec_seq;

    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_opcode;
    logic [AW-1:0] cmd_src_a, cmd_src_b, cmd_dst, cmd_len;
    logic [63:0]   cfg_q, cfg_mu;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [63:0]   rd_data_a, rd_data_b;
    logic [2:0]    alu_opcode;
    logic [63:0]   alu_a, alu_b, alu_q, alu_mu, alu_res;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          busy, done, err;

    vec_seq #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cfg_q(cfg_q), .cfg_mu(cfg_mu),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_q(alu_q),
        .alu_mu(alu_mu), .alu_res(alu_res),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem_a [0:1023];
    logic [63:0] mem_b [0:1023];

    // Operand memories: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_b <= mem_b[rd_addr_b];
        end
    end

    // Reference modular ALU (operands assumed already reduced below q)
    always_comb begin
        logic [127:0] prod;
        prod    = 128'd0;
        alu_res = 64'd0;
        if (alu_q != 64'd0) begin
            case (alu_opcode)
                3'b000: alu_res = 64'(({1'b0, alu_a} + {1'b0, alu_b}) % {1'b0, alu_q});
                3'b001: alu_res = (alu_a >= alu_b) ? (alu_a - alu_b) : (alu_a + alu_q - alu_b);
                3'b010: begin
                    prod    = {64'd0, alu_a} * {64'd0, alu_b};
                    alu_res = 64'(prod % {64'd0, alu_q});
                end
                default: alu_res = 64'd0;
            endcase
        end else begin
            alu_res = 64'd0;
        end
    end

    typedef struct packed {
        logic [2:0]       op;
        logic [AW-1:0]    sa;
        logic [AW-1:0]    sb;
        logic [AW-1:0]    dst;
        logic [AW-1:0]    len;
        logic [63:0]      q;
        logic [3:0][63:0] a;
        logic [3:0][63:0] b;
        logic [3:0][63:0] ex;
        logic             ex_err;
    } vec_t;

    vec_t vt [8];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Preload operands, present the command and return just after the accepting edge
    task automatic issue(input vec_t v, input string tag);
        logic [AW-1:0] pa, pb;
        bit got;
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pa = v.sa + AW'(i);
            pb = v.sb + AW'(i);
            mem_a[pa] = v.a[i];
            mem_b[pb] = v.b[i];
        end
        cmd_opcode = v.op;
        cmd_src_a  = v.sa;
        cmd_src_b  = v.sb;
        cmd_dst    = v.dst;
        cmd_len    = v.len;
        cfg_q      = v.q;
        cfg_mu     = v.q ^ 64'h1234;
        cmd_valid  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({tag, " accept_timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_opcode = 3'b010;
        cmd_src_a  = 10'd700;
        cmd_src_b  = 10'd701;
        cmd_dst    = 10'd702;
        cmd_len    = 10'd9;
        cfg_q      = 64'd5;
        cfg_mu     = 64'd0;
    endtask

    // Observe one command from the cycle after accept until done, checking as it goes
    task automatic collect(input vec_t v, input string tag);
        int n_exp, rd_cnt, wr_cnt, first_rd, first_wr, last_wr, done_cyc, stray_err, holdoff_bad;
        logic [AW-1:0] ea;
        logic err_at_done;
        n_exp       = ((v.op <= 3'd2) && (v.len != 10'd0)) ? int'(v.len) : 0;
        rd_cnt      = 0;
        wr_cnt      = 0;
        first_rd    = -1;
        first_wr    = -1;
        last_wr     = -1;
        done_cyc    = -1;
        stray_err   = 0;
        holdoff_bad = 0;
        err_at_done = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (busy && cmd_ready) holdoff_bad++;
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                ea = v.sa + AW'(rd_cnt);
                check($sformatf("%s rd_addr_a[%0d]", tag, rd_cnt), 64'(rd_addr_a), 64'(ea));
                ea = v.sb + AW'(rd_cnt);
                check($sformatf("%s rd_addr_b[%0d]", tag, rd_cnt), 64'(rd_addr_b), 64'(ea));
                rd_cnt++;
            end
            if (wr_en) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                ea = v.dst + AW'(wr_cnt);
                check($sformatf("%s wr_addr[%0d]", tag, wr_cnt), 64'(wr_addr), 64'(ea));
                if (wr_cnt < 4)
                    check($sformatf("%s wr_data[%0d]", tag, wr_cnt), wr_data, v.ex[wr_cnt]);
                wr_cnt++;
            end
            if (err && !done) stray_err++;
            if (done) begin
                done_cyc    = cyc;
                err_at_done = err;
                break;
            end
        end
        if (done_cyc < 0) check({tag, " done_timeout"}, 64'd0, 64'd1);
        check({tag, " rd_count"}, 64'(rd_cnt), 64'(n_exp));
        check({tag, " wr_count"}, 64'(wr_cnt), 64'(n_exp));
        check({tag, " err"}, 64'(err_at_done), 64'(v.ex_err));
        check({tag, " err_stray"}, 64'(stray_err), 64'd0);
        check({tag, " holdoff"}, 64'(holdoff_bad), 64'd0);
        check({tag, " alu_q_latched"}, alu_q, v.q);
        check({tag, " alu_mu_latched"}, alu_mu, v.q ^ 64'h1234);
        if (n_exp > 0) begin
            check({tag, " first_rd_cycle"}, 64'(first_rd), 64'd1);
            check({tag, " wr_latency"}, 64'(first_wr - first_rd), 64'd2);
            check({tag, " wr_back_to_back"}, 64'(last_wr - first_wr), 64'(n_exp - 1));
            check({tag, " done_cycle"}, 64'(done_cyc), 64'(last_wr + 1));
        end else begin
            check({tag, " done_cycle"}, 64'(done_cyc), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_seen;
        vec_t big;

        for (int i = 0; i < 8; i++) vt[i] = '0;
        // add q=97: 1+2, 50+60, 96+1, 0+0
        vt[0].op = 3'b000; vt[0].sa = 10'd10; vt[0].sb = 10'd20; vt[0].dst = 10'd30;
        vt[0].len = 10'd4; vt[0].q = 64'd97;
        vt[0].a  = {64'd0, 64'd96, 64'd50, 64'd1};
        vt[0].b  = {64'd0, 64'd1,  64'd60, 64'd2};
        vt[0].ex = {64'd0, 64'd0,  64'd13, 64'd3};
        // sub: 5-7 mod 97
        vt[1].op = 3'b001; vt[1].sa = 10'd100; vt[1].sb = 10'd200; vt[1].dst = 10'd300;
        vt[1].len = 10'd1; vt[1].q = 64'd97;
        vt[1].a = {192'd0, 64'd5}; vt[1].b = {192'd0, 64'd7}; vt[1].ex = {192'd0, 64'd95};
        // illegal opcode 101, len 8
        vt[2].op = 3'b101; vt[2].sa = 10'd40; vt[2].sb = 10'd41; vt[2].dst = 10'd42;
        vt[2].len = 10'd8; vt[2].q = 64'd97; vt[2].ex_err = 1'b1;
        // len 0 add
        vt[3].op = 3'b000; vt[3].sa = 10'd50; vt[3].sb = 10'd51; vt[3].dst = 10'd52;
        vt[3].len = 10'd0; vt[3].q = 64'd97;
        // address wrap on reads and writes
        vt[4].op = 3'b000; vt[4].sa = 10'd1021; vt[4].sb = 10'd1023; vt[4].dst = 10'd1022;
        vt[4].len = 10'd3; vt[4].q = 64'd97;
        vt[4].a  = {64'd0, 64'd30, 64'd20, 64'd10};
        vt[4].b  = {64'd0, 64'd3,  64'd2,  64'd1};
        vt[4].ex = {64'd0, 64'd33, 64'd22, 64'd11};
        // mult: 10*10, 20*6 mod 97
        vt[5].op = 3'b010; vt[5].sa = 10'd600; vt[5].sb = 10'd610; vt[5].dst = 10'd620;
        vt[5].len = 10'd2; vt[5].q = 64'd97;
        vt[5].a  = {128'd0, 64'd20, 64'd10};
        vt[5].b  = {128'd0, 64'd6,  64'd10};
        vt[5].ex = {128'd0, 64'd23, 64'd3};
        // illegal opcode 011 with len 0 still flags err
        vt[6].op = 3'b011; vt[6].sa = 10'd1; vt[6].sb = 10'd2; vt[6].dst = 10'd3;
        vt[6].len = 10'd0; vt[6].q = 64'd97; vt[6].ex_err = 1'b1;
        // sub wrap: 0-1 mod 97
        vt[7].op = 3'b001; vt[7].sa = 10'd800; vt[7].sb = 10'd801; vt[7].dst = 10'd802;
        vt[7].len = 10'd1; vt[7].q = 64'd97;
        vt[7].a = {192'd0, 64'd0}; vt[7].b = {192'd0, 64'd1}; vt[7].ex = {192'd0, 64'd96};

        cmd_valid = 1'b0; cmd_opcode = 3'b000; cmd_src_a = '0; cmd_src_b = '0;
        cmd_dst = '0; cmd_len = '0; cfg_q = 64'd0; cfg_mu = 64'd0;
        rd_data_a = 64'd0; rd_data_b = 64'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        check("reset cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset rd_en", 64'(rd_en), 64'd0);
        check("reset wr_en", 64'(wr_en), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            issue(vt[i], $sformatf("vec%0d", i));
            collect(vt[i], $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
        end

        // Command held valid while busy must be taken once the sequencer returns to IDLE
        issue(vt[1], "hold_first");
        cmd_opcode = vt[0].op; cmd_src_a = vt[0].sa; cmd_src_b = vt[0].sb;
        cmd_dst = vt[0].dst; cmd_len = vt[0].len; cfg_q = vt[0].q;
        cfg_mu = vt[0].q ^ 64'h1234; cmd_valid = 1'b1;
        collect(vt[1], "hold_first");
        issue(vt[0], "hold_second");
        collect(vt[0], "hold_second");
        repeat (2) @(negedge clk);

        // Reset in the middle of a 16-element run
        big = '0;
        big.op = 3'b000; big.sa = 10'd0; big.sb = 10'd0; big.dst = 10'd500;
        big.len = 10'd16; big.q = 64'd97;
        issue(big, "rst_run");
        repeat (4) @(negedge clk);
        check("rst_run rd_en_before", 64'(rd_en), 64'd1);
        check("rst_run wr_en_before", 64'(wr_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_run wr_en", 64'(wr_en), 64'd0);
        check("rst_run rd_en", 64'(rd_en), 64'd0);
        check("rst_run cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_run busy", 64'(busy), 64'd0);
        check("rst_run wr_addr", 64'(wr_addr), 64'd0);
        check("rst_run rd_addr_a", 64'(rd_addr_a), 64'd0);
        wr_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (wr_en || rd_en || busy) wr_seen++;
        end
        check("rst_run activity_after_reset", 64'(wr_seen), 64'd0);
        issue(vt[5], "post_rst_mult");
        collect(vt[5], "post_rst_mult");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_seq.md
VEC_SEQ -- requirements
Module: vec_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the width of operand/result memory addresses and of the vector length.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1, command present.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted this cycle when high together with cmd_valid.
REQ-006 SHALL have port cmd_opcode, input, 3, vector op: 000 add, 001 sub, 010 mult, others illegal.
REQ-007 SHALL have ports cmd_src_a, cmd_src_b and cmd_dst, input, ADDR_W each, base addresses.
REQ-008 SHALL have port cmd_len, input, ADDR_W, element count; 0 means no-op.
REQ-009 SHALL have ports cfg_q and cfg_mu, input, 64 each, modulus and Barrett constant, sampled at command accept.
REQ-010 SHALL have ports rd_en, output, 1, and rd_addr_a and rd_addr_b, output, ADDR_W, operand memory read request.
REQ-011 SHALL have ports rd_data_a and rd_data_b, input, 64, valid exactly one cycle after rd_en.
REQ-012 SHALL have ports alu_opcode (output, 3), alu_a, alu_b, alu_q and alu_mu (output, 64), and alu_res (input, 64), connecting to the combinational modular ALU.
REQ-013 SHALL have ports wr_en (output, 1), wr_addr (output, ADDR_W) and wr_data (output, 64), result memory write.
REQ-014 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, one-cycle pulse coincident with done).

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN and FIN.
REQ-016 SHALL drive cmd_ready high only in IDLE; busy SHALL be high in every state except IDLE.
REQ-017 On accept, SHALL latch opcode, bases, len, q and mu; later changes on cmd_* and cfg_* SHALL have no effect until the next accept.
REQ-018 On accept with legal opcode and len>0: IDLE->RUN; otherwise IDLE->FIN, with no rd_en and no wr_en issued.
REQ-019 In RUN, SHALL assert rd_en every cycle for elements i = 0..len-1, with rd_addr_a = src_a+i and rd_addr_b = src_b+i modulo 2^ADDR_W; after issuing element len-1, RUN->DRAIN.
REQ-020 SHALL drive alu_a and alu_b from rd_data_a and rd_data_b, and alu_opcode, alu_q and alu_mu from the latched values.
REQ-021 SHALL register alu_res into wr_data; wr_en for element i SHALL be high exactly 2 cycles after rd_en for element i, with wr_addr = dst+i modulo 2^ADDR_W.
REQ-022 The first rd_en SHALL occur in the cycle after accept; throughput SHALL be one element per cycle; writes SHALL occur in ascending i order.
REQ-023 DRAIN SHALL last until the final wr_en has been issued, then DRAIN->FIN.
REQ-024 FIN SHALL last one cycle, pulse done, and pulse err if and only if the latched opcode is illegal; FIN->IDLE.
REQ-025 len = 2^ADDR_W-1 SHALL process all elements; address wrap past the top of memory SHALL wrap to 0 without error.
REQ-026 A cmd_valid arriving while busy SHALL be held off (cmd_ready low) and SHALL NOT be lost if held by the requester.

Reset
REQ-027 rst_n low SHALL immediately force state to IDLE and drive the following outputs to 0: rd_en, wr_en, done, err, busy and all address/data outputs; cmd_ready SHALL be 1.
REQ-028 Reset mid-operation SHALL abort the vector with no further writes; the first command after reset deasserts SHALL behave normally.

Verification
REQ-029 add, q=97, len=4, A=[1,50,96,0], B=[2,60,1,0] -> writes [3,13,0,0] to dst..dst+3 on 4 consecutive cycles; first wr_en 2 cycles after first rd_en; done pulses in the cycle after the final write.
REQ-030 sub, len=1, A=[5], B=[7], q=97 -> single write of 95; err stays 0.
REQ-031 opcode 3'b101, len=8 -> no rd_en and no wr_en; done=1 and err=1 in the cycle after accept.
REQ-032 len=0, add -> done in the cycle after accept, err=0, no memory activity.
REQ-033 With ADDR_W=10, dst=1022 and len=3 -> wr_addr sequence 1022, 1023, 0.
REQ-034 rst_n asserted during RUN of len=16 -> wr_en=0 in the same cycle, no further writes, cmd_ready=1; a subsequent len=2 mult command completes correctly.
